// File: rtl/wb_writer.sv
// Writeback-stage producer for the integer register file write port.
// Retires instructions from MEM over a valid/ready handshake. Loads wait
// for the data-memory response, which is aligned and extended before the
// write. Also reports the outstanding load to ID and counts retirements.
module wb_writer #(
   parameter int XLEN         = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  wreg_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [XLEN-1:0]       wdata_i,
   input  logic                  is_load_i,
   input  logic [2:0]            funct3_i,
   input  logic [1:0]            addr_lo_i,
   input  logic                  dmem_rvalid_i,
   input  logic [XLEN-1:0]       dmem_rdata_i,
   output logic                  we_o,
   output logic [REG_ADDR_W-1:0] waddr_o,
   output logic [XLEN-1:0]       wdata_o,
   output logic                  pending_o,
   output logic [REG_ADDR_W-1:0] pending_addr_o,
   output logic                  err_o,
   output logic [63:0]           instret_o
);

   localparam int CNT_W = (LOAD_TIMEOUT < 1) ? 1 : $clog2(LOAD_TIMEOUT + 1);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Captured context of the outstanding load
   logic [REG_ADDR_W-1:0] ld_addr_q;
   logic [2:0]            ld_f3_q;
   logic [1:0]            ld_lo_q;
   logic                  ld_wreg_q;
   logic [CNT_W-1:0]      to_cnt_q;

   logic take;
   logic timeout;

   // Aligned load data
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;
   logic            f3_legal;

   // Commit request, registered onto the write port next edge
   logic                  wr_en_d;
   logic [REG_ADDR_W-1:0] wr_addr_d;
   logic [XLEN-1:0]       wr_data_d;
   logic                  err_d;
   logic                  retire_d;

   assign take    = valid_i && ready_o;
   // The count reaching the limit only ends the load if no response shows
   // up in the same cycle; the response check is ordered first below.
   assign timeout = (to_cnt_q == CNT_W'(LOAD_TIMEOUT));

   // Select and extend the addressed byte/halfword of the response word
   always_comb begin
      ld_byte  = dmem_rdata_i[{ld_lo_q, 3'b000} +: 8];
      ld_half  = dmem_rdata_i[{ld_lo_q[1], 4'b0000} +: 16];
      ld_data  = dmem_rdata_i;
      f3_legal = 1'b1;
      case (ld_f3_q)
         3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b010:  ld_data = dmem_rdata_i;
         3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
         default: f3_legal = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned
      // (which would infer a latch).
      state_d = state_q;
      case (state_q)
         IDLE:     if (take && is_load_i) state_d = WAIT_RSP;
         WAIT_RSP: if (dmem_rvalid_i || timeout) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Handshake, hazard outputs and the commit request for this cycle
   always_comb begin
      ready_o        = (state_q == IDLE);
      pending_o      = (state_q == WAIT_RSP);
      pending_addr_o = (state_q == WAIT_RSP) ? ld_addr_q : '0;
      wr_en_d        = 1'b0;
      wr_addr_d      = waddr_i;
      wr_data_d      = wdata_i;
      err_d          = 1'b0;
      retire_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (take && !is_load_i) begin
               wr_en_d  = wreg_i && (waddr_i != '0);
               retire_d = 1'b1;
            end
         end
         WAIT_RSP: begin
            wr_addr_d = ld_addr_q;
            wr_data_d = ld_data;
            if (dmem_rvalid_i) begin
               // funct3 legality is judged when the data arrives
               if (f3_legal) begin
                  wr_en_d  = ld_wreg_q && (ld_addr_q != '0);
                  retire_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (timeout) begin
               err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Capture load context on acceptance and run the response timeout counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ld_addr_q <= '0;
         ld_f3_q   <= '0;
         ld_lo_q   <= '0;
         ld_wreg_q <= 1'b0;
         to_cnt_q  <= '0;
      end else if (take && is_load_i) begin
         ld_addr_q <= waddr_i;
         ld_f3_q   <= funct3_i;
         ld_lo_q   <= addr_lo_i;
         ld_wreg_q <= wreg_i;
         to_cnt_q  <= '0;
      end else if (state_q == WAIT_RSP && !dmem_rvalid_i && !timeout) begin
         to_cnt_q <= to_cnt_q + CNT_W'(1);
      end
   end

   // Register file write port, error pulse and retirement counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_o      <= 1'b0;
         waddr_o   <= '0;
         wdata_o   <= '0;
         err_o     <= 1'b0;
         instret_o <= '0;
      end else begin
         we_o  <= wr_en_d;
         err_o <= err_d;
         // Address/data hold their last written values between writes
         if (wr_en_d) begin
            waddr_o <= wr_addr_d;
            wdata_o <= wr_data_d;
         end
         if (retire_d) instret_o <= instret_o + 64'd1;
      end
   end

endmodule
